// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// mem_wb_stage : load/store data-memory access (req/ack) plus MEM/WB register
// Revision     : 1.0
// ============================================================================
module mem_wb_stage #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int          MEM_AW      = 16,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WB_EN,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic [31:0]       ALU_result,
  input  logic [31:0]       Val_Rm,
  input  logic [3:0]        Dest,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              freeze,
  output logic              writeBackEn,
  output logic [3:0]        Dest_wb,
  output logic [31:0]       Result_WB,
  output logic              mem_err
);

  localparam logic [31:0] c_base_addr = 32'(BASE_ADDR);
  localparam logic [7:0]  c_timeout   = 8'(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              mem_err_q, mem_err_d;
  logic              wb_en_q, wb_en_d;
  logic [3:0]        dest_wb_q, dest_wb_d;
  logic [31:0]       result_wb_q, result_wb_d;

  logic              w_access;
  logic              w_freeze;
  logic              w_load_sel;
  logic [7:0]        w_cnt_inc;
  logic [MEM_AW-1:0] w_word_addr;

  assign w_access    = MEM_R_EN | MEM_W_EN;
  // A simultaneous read+write is a store, so only a pure load returns memory data.
  assign w_load_sel  = MEM_R_EN & ~MEM_W_EN;
  assign w_cnt_inc   = cnt_q + 8'd1;
  assign w_word_addr = MEM_AW'((ALU_result - c_base_addr) >> 2);
  assign w_freeze    = ((state_q == ST_IDLE) & w_access) | (state_q == ST_WAIT);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    load_data_d = load_data_q;
    mem_err_d   = mem_err_q;

    case (state_q)
      ST_IDLE: begin
        mem_req_d = 1'b0;
        if (w_access) begin
          mem_we_d    = MEM_W_EN;
          mem_addr_d  = w_word_addr;
          mem_wdata_d = Val_Rm;
          cnt_d       = 8'd0;
          mem_req_d   = 1'b1;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = w_cnt_inc;
        if (mem_ack) begin
          load_data_d = mem_rdata;
          mem_req_d   = 1'b0;
          state_d     = ST_DONE;
        end else if (w_cnt_inc == c_timeout) begin
          // Abandoned access: hand the pipeline a zero and remember the fault.
          load_data_d = 32'd0;
          mem_err_d   = 1'b1;
          mem_req_d   = 1'b0;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        mem_req_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // MEM/WB register: a stalled cycle becomes a bubble while the data fields hold.
  always_comb begin
    wb_en_d     = 1'b0;
    dest_wb_d   = dest_wb_q;
    result_wb_d = result_wb_q;
    if (!w_freeze) begin
      wb_en_d     = WB_EN;
      dest_wb_d   = Dest;
      result_wb_d = w_load_sel ? load_data_q : ALU_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      load_data_q <= 32'd0;
      mem_err_q   <= 1'b0;
      wb_en_q     <= 1'b0;
      dest_wb_q   <= 4'd0;
      result_wb_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      load_data_q <= load_data_d;
      mem_err_q   <= mem_err_d;
      wb_en_q     <= wb_en_d;
      dest_wb_q   <= dest_wb_d;
      result_wb_q <= result_wb_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign freeze      = w_freeze;
  assign writeBackEn = wb_en_q;
  assign Dest_wb     = dest_wb_q;
  assign Result_WB   = result_wb_q;
  assign mem_err     = mem_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// tb_mem_wb_stage : transaction-level model bench for mem_wb_stage
// Revision        : 1.0
// ============================================================================
module tb_mem_wb_stage;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        WB_EN = 1'b0, MEM_R_EN = 1'b0, MEM_W_EN = 1'b0;
  logic [31:0] ALU_result = 32'd0, Val_Rm = 32'd0, mem_rdata = 32'd0;
  logic [3:0]  Dest = 4'd0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, freeze, writeBackEn, mem_err;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, Result_WB;
  logic [3:0]  Dest_wb;

  int vectors = 0;
  int miscompares = 0;

  // Expected architectural state carried between instructions.
  logic        exp_err = 1'b0;
  logic        p_wben = 1'b0;
  logic [3:0]  p_dest = 4'd0;
  logic [31:0] p_res = 32'd0;

  always #5 clk = ~clk;

  mem_wb_stage #(.BASE_ADDR(1024), .MEM_AW(16), .ACK_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .ALU_result(ALU_result), .Val_Rm(Val_Rm), .Dest(Dest),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .freeze(freeze),
    .writeBackEn(writeBackEn), .Dest_wb(Dest_wb), .Result_WB(Result_WB), .mem_err(mem_err)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // One instruction: ack_cycle is the WAIT cycle (1-based) carrying the ack; 0 or >T means none.
  task automatic run_instr(input logic wb, input logic re, input logic we, input logic [3:0] dest,
                           input logic [31:0] alu, input logic [31:0] rm, input logic [31:0] rdata,
                           input int ack_cycle, input logic noise);
    logic        acc;
    logic        acked;
    logic [15:0] ea;
    logic [31:0] ld;
    acc = re | we;
    ea  = 16'((alu - 32'd1024) / 4);
    ld  = 32'd0;

    vectors++;
    if ({writeBackEn, Dest_wb, Result_WB} !== {p_wben, p_dest, p_res}) begin
      miscompares++;
      $display("FAIL wb_regs: got en=%b dest=%0d res=%h, want en=%b dest=%0d res=%h",
               writeBackEn, Dest_wb, Result_WB, p_wben, p_dest, p_res);
    end

    WB_EN = wb; MEM_R_EN = re; MEM_W_EN = we; Dest = dest; ALU_result = alu; Val_Rm = rm;
    mem_ack = noise; mem_rdata = $urandom;
    #1;
    vectors++;
    if ({freeze, mem_req} !== {acc, 1'b0}) begin
      miscompares++;
      $display("FAIL issue: got freeze=%b req=%b, want freeze=%b req=0", freeze, mem_req, acc);
    end

    if (acc) begin
      acked = 1'b0;
      for (int w = 1; w <= T; w++) begin
        @(posedge clk); #1;
        mem_ack = 1'b0;
        vectors++;
        if ({mem_req, freeze, mem_we, mem_addr, mem_wdata, writeBackEn, mem_err} !==
            {1'b1, 1'b1, we, ea, rm, 1'b0, exp_err}) begin
          miscompares++;
          $display("FAIL wait%0d: got req=%b frz=%b we=%b addr=%h wd=%h wben=%b err=%b, want 1 1 %b %h %h 0 %b",
                   w, mem_req, freeze, mem_we, mem_addr, mem_wdata, writeBackEn, mem_err, we, ea, rm, exp_err);
        end
        if (w == ack_cycle) begin
          mem_ack = 1'b1; mem_rdata = rdata; ld = rdata; acked = 1'b1;
          break;
        end
      end
      if (!acked) exp_err = 1'b1;
      @(posedge clk); #1;
      mem_ack = noise; mem_rdata = $urandom;
      vectors++;
      if ({mem_req, freeze, writeBackEn, mem_err} !== {1'b0, 1'b0, 1'b0, exp_err}) begin
        miscompares++;
        $display("FAIL done: got req=%b frz=%b wben=%b err=%b, want 0 0 0 %b",
                 mem_req, freeze, writeBackEn, mem_err, exp_err);
      end
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    p_wben = wb;
    p_dest = dest;
    p_res  = (re && !we) ? ld : alu;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, writeBackEn, Dest_wb, Result_WB, mem_err, freeze} !== '0) begin
      miscompares++;
      $display("FAIL reset: got req=%b we=%b addr=%h wd=%h wben=%b dest=%0d res=%h err=%b frz=%b, want all 0",
               mem_req, mem_we, mem_addr, mem_wdata, writeBackEn, Dest_wb, Result_WB, mem_err, freeze);
    end
    rst = 1'b0;
    exp_err = 1'b0; p_wben = 1'b0; p_dest = 4'd0; p_res = 32'd0;
  endtask

  task automatic test_alu();
    run_instr(1'b1, 1'b0, 1'b0, 4'd3, 32'h55, 32'h0, 32'h0, 0, 1'b0);
  endtask

  task automatic test_load();
    run_instr(1'b1, 1'b1, 1'b0, 4'd5, 32'd1032, 32'h0, 32'hDEADBEEF, 3, 1'b0);
    run_instr(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 0, 1'b0);
  endtask

  task automatic test_store();
    run_instr(1'b0, 1'b0, 1'b1, 4'd7, 32'd1028, 32'h12345678, 32'hFFFF0000, 1, 1'b0);
    run_instr(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 0, 1'b0);
  endtask

  task automatic test_timeout();
    run_instr(1'b1, 1'b1, 1'b0, 4'd9, 32'd1100, 32'h0, 32'hCAFEF00D, 0, 1'b0);
    run_instr(1'b1, 1'b0, 1'b0, 4'd2, 32'h77, 32'h0, 32'h0, 0, 1'b1);
    vectors++;
    if (mem_err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky: got mem_err=%b, want 1", mem_err);
    end
  endtask

  task automatic test_back_to_back();
    run_instr(1'b1, 1'b0, 1'b0, 4'd1, 32'h1111, 32'h0, 32'h0, 0, 1'b0);
    run_instr(1'b1, 1'b0, 1'b0, 4'd2, 32'h2222, 32'h0, 32'h0, 0, 1'b1);
    run_instr(1'b1, 1'b1, 1'b1, 4'd4, 32'd2048, 32'hA5A5A5A5, 32'h3333, 2, 1'b1);
    run_instr(1'b1, 1'b1, 1'b0, 4'd6, 32'd1024, 32'h0, 32'h0BADF00D, 1, 1'b1);
  endtask

  task automatic test_random();
    logic [1:0] kind;
    for (int i = 0; i < 40; i++) begin
      kind = 2'($urandom_range(0, 3));
      run_instr(1'($urandom_range(0, 1)), kind[0], kind[1], 4'($urandom), $urandom, $urandom,
                $urandom, $urandom_range(0, T + 1), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_access();
    vectors++;
    if ({writeBackEn, Dest_wb, Result_WB} !== {p_wben, p_dest, p_res}) begin
      miscompares++;
      $display("FAIL wb_regs_pre_rst: got en=%b dest=%0d res=%h, want en=%b dest=%0d res=%h",
               writeBackEn, Dest_wb, Result_WB, p_wben, p_dest, p_res);
    end
    WB_EN = 1'b1; MEM_R_EN = 1'b1; MEM_W_EN = 1'b0; Dest = 4'd8; ALU_result = 32'd1040;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_req: got mem_req=%b, want 1", mem_req);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    WB_EN = 1'b0; MEM_R_EN = 1'b0; Dest = 4'd0; ALU_result = 32'd0;
    #1;
    vectors++;
    if ({mem_req, freeze, writeBackEn, mem_err, Dest_wb, Result_WB} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid: got req=%b frz=%b wben=%b err=%b dest=%0d res=%h, want all 0",
               mem_req, freeze, writeBackEn, mem_err, Dest_wb, Result_WB);
    end
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hBEEFBEEF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    for (int c = 0; c < 2; c++) begin
      vectors++;
      if ({mem_req, freeze, writeBackEn, Result_WB} !== '0) begin
        miscompares++;
        $display("FAIL late_ack%0d: got req=%b frz=%b wben=%b res=%h, want all 0",
                 c, mem_req, freeze, writeBackEn, Result_WB);
      end
      @(posedge clk); #1;
    end
    exp_err = 1'b0; p_wben = 1'b0; p_dest = 4'd0; p_res = 32'd0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid_access();
    run_instr(1'b1, 1'b0, 1'b0, 4'd15, 32'hFEEDFACE, 32'h0, 32'h0, 0, 1'b0);
    run_instr(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
